display_frame_reader_ctrl: RTL
==============================

Name: display_frame_reader_ctrl

Overview:
- Schedules display frame-buffer reads. Issues burst read requests to the display DMA read channel, one frame per display vsync.
- Chooses between two frame buffers (ping-pong) in step with the camera writer.
- Limits outstanding beats so the display FIFO/upscaler path is not overrun, and flags missed or late frames.
- Sits between the camera write-side frame buffer manager, the DMA read engine and the display pipeline.

Parameters:
- FRAME_WIDTH, 540: input frame width in pixels; must be even (2 pixels per 64-bit beat).
- FRAME_HEIGHT, 540: input frame height in lines.
- FB_BASE, 32'h0010_0000: byte address of buffer 0.
- FB_STRIDE, 32'h0020_0000: byte spacing between buffer 0 and buffer 1.
- BYTES_PER_BEAT, 8: DMA data width in bytes.
- BURST_BEATS, 64: maximum beats per request, range 1..256.
- MAX_OUTSTANDING, 256: credit limit in beats; must be ≥ BURST_BEATS.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; 0 stops new frames after the current frame drains
- vs_fall  in  1  single-cycle pulse at display vsync falling edge
- wr_frame_done  in  1  pulse: camera writer completed a buffer
- wr_buf_idx  in  1  buffer index completed, qualified by wr_frame_done
- beat_rx  in  1  one read beat accepted (rvalid & rready & full rkeep)
- req_valid  out  1  read request valid
- req_ready  in  1  DMA accepts request
- req_addr  out  32  request byte address
- req_len  out  8  request beats minus 1
- rd_buf_idx  out  1  buffer currently being read; writer must avoid it
- rd_busy  out  1  high from frame start until the last beat is received
- frame_miss  out  1  sticky: vs_fall arrived while a frame was still in progress
- frame_miss_cnt  out  16  saturating count of missed vsyncs
- frames_read  out  16  wrapping count of completed frames

Behaviour:
- Reset values: req_valid=0, req_addr=0, req_len=0, rd_buf_idx=0, rd_busy=0, frame_miss=0, all counters 0. Internal state: state=IDLE, latest_buf=0, new_avail=0, outstanding=0.
- Constants: FRAME_BEATS = FRAME_WIDTH*FRAME_HEIGHT/2. beat_idx is 18 bits or wider. outstanding is $clog2(MAX_OUTSTANDING)+1 bits.
- Write-side tracking: on wr_frame_done, set latest_buf=wr_buf_idx and new_avail=1. This update takes effect in every state.
- FSM states and transitions:
  - IDLE: if enable=1, go to WAIT_VS.
  - WAIT_VS: on vs_fall with enable=1:
    - latch rd_buf_idx=latest_buf; clear new_avail;
    - beat_idx=0; rd_busy=1; go to ISSUE next cycle.
    - If new_avail=0 (no new frame written), re-read the previous buffer anyway.
    - If enable=0 while in WAIT_VS, go to IDLE.
  - ISSUE: compute len=min(BURST_BEATS, FRAME_BEATS-beat_idx).
    - If outstanding+len ≤ MAX_OUTSTANDING, assert req_valid with req_addr=FB_BASE+rd_buf_idx*FB_STRIDE+beat_idx*BYTES_PER_BEAT and req_len=len-1; go to REQ.
    - Otherwise stay in ISSUE; req_valid stays 0.
  - REQ: hold req_valid, req_addr and req_len stable until req_ready.
    - On handshake: outstanding+=len; beat_idx+=len; deassert req_valid next cycle.
    - Then go to DRAIN if beat_idx==FRAME_BEATS, else to ISSUE.
  - DRAIN: when outstanding==0, clear rd_busy, increment frames_read, go to WAIT_VS (or IDLE if enable=0).
- Credit accounting: outstanding decrements by 1 on each beat_rx. If a request handshake and a beat_rx fall in the same cycle, apply the net change (+len-1). beat_rx while outstanding==0 is ignored; this is an assertion in the bench.
- Latency: vs_fall to first req_valid is 2 cycles, when credit is available.
- vs_fall in ISSUE, REQ or DRAIN: no restart. Set frame_miss, increment frame_miss_cnt (saturate at 16'hFFFF), and let the current frame finish. The next vs_fall seen in WAIT_VS starts the next frame.
- enable deassert mid-frame: the frame completes normally; the FSM then returns to IDLE.
- rst mid-frame: all state clears immediately. The bench is responsible for flushing the DMA; stray beat_rx after reset are ignored.
- No combinational path from req_ready or beat_rx to req_valid.

Decomposition:
- Shared package display_pkg:
  - FSM state enum (IDLE, WAIT_VS, ISSUE, REQ, DRAIN);
  - FRAME_BEATS computation function;
  - address-width constant ADDR_W=32.
- One sub-module is natural: display_read_credit. It holds the outstanding-beat counter, takes add_len/add_en/beat_rx and outputs has_credit(len). It is reusable by the camera write controller.

Test Plan:
- FRAME 16x4, BURST_BEATS 8, req_ready always 1, beat_rx returned 4 cycles after each request → per frame: 4 requests with addresses FB_BASE+0, +64, +128, +192 and req_len=7; frames_read=1; rd_busy low after the 32nd beat.
- FRAME 18x2 (18 beats), BURST 8 → requests of lengths 8, 8, 2 (req_len 7, 7, 1); last address FB_BASE+128.
- wr_frame_done with wr_buf_idx=1, then vs_fall → rd_buf_idx=1 and first address FB_BASE+FB_STRIDE. With no further writes, the next vs_fall re-reads buffer 1.
- MAX_OUTSTANDING 16, BURST 8, beat_rx withheld → exactly 2 requests issued, req_valid stays 0. Release 8 beats → third request issues.
- req_ready held low 10 cycles → req_valid, req_addr and req_len stay stable for all 10 cycles; a single handshake follows.
- vs_fall injected during DRAIN → frame_miss=1, frame_miss_cnt=1, no new request until the following vs_fall. Assert rst mid-frame → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the display frame reader.
package display_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        ISSUE,
        REQ,
        DRAIN
    } rd_state_t;

    // Two pixels per 64-bit beat, so a frame is width*height/2 beats.
    function automatic int frame_beats(input int width, input int height);
        return (width * height) / 2;
    endfunction

endpackage

// File: rtl/display_frame_reader_ctrl_if.sv
// DMA read channel: burst requests out, accepted read beats back.
interface display_frame_reader_ctrl_if;
    import display_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic              beat_rx;

    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, beat_rx
    );

    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, beat_rx
    );

endinterface

// File: rtl/display_read_credit.sv
// Outstanding-beat credit counter shared by the frame read/write controllers.
module display_read_credit #(
    parameter int MAX_OUTSTANDING = 256,
    parameter int LEN_W           = 9,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic [LEN_W-1:0] add_len,
    input  logic             beat_rx,
    input  logic [LEN_W-1:0] chk_len,
    output logic             has_credit,
    output logic [CNT_W-1:0] outstanding
);

    logic [31:0] next_cnt;

    assign has_credit = (32'(outstanding) + 32'(chk_len)) <= 32'(MAX_OUTSTANDING);

    // Net change per cycle: granted burst adds, each beat retires one; a beat with nothing owed is dropped.
    always_comb begin
        next_cnt = 32'(outstanding);
        if (add_en) begin
            next_cnt = next_cnt + 32'(add_len);
        end
        if (beat_rx && (outstanding != '0)) begin
            next_cnt = next_cnt - 32'd1;
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= CNT_W'(next_cnt);
        end
    end

endmodule

// File: rtl/display_frame_reader_ctrl.sv
// Display frame-buffer read scheduler: one frame per vsync from the ping-pong buffers.
//
//   state   | meaning
//   IDLE    | disabled, no frame scheduled
//   WAIT_VS | armed, waiting for display vsync to start a frame
//   ISSUE   | sizing next burst, waiting for beat credit
//   REQ     | request presented, waiting for DMA accept
//   DRAIN   | all bursts issued, waiting for the last beats to land
module display_frame_reader_ctrl
    import display_pkg::*;
#(
    parameter int              FRAME_WIDTH     = 540,
    parameter int              FRAME_HEIGHT    = 540,
    parameter logic [ADDR_W-1:0] FB_BASE       = 32'h0010_0000,
    parameter logic [ADDR_W-1:0] FB_STRIDE     = 32'h0020_0000,
    parameter int              BYTES_PER_BEAT  = 8,
    parameter int              BURST_BEATS     = 64,
    parameter int              MAX_OUTSTANDING = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         vs_fall,
    input  logic                         wr_frame_done,
    input  logic                         wr_buf_idx,
    display_frame_reader_ctrl_if.master  dma,
    output logic                         rd_buf_idx,
    output logic                         rd_busy,
    output logic                         frame_miss,
    output logic [15:0]                  frame_miss_cnt,
    output logic [15:0]                  frames_read
);

    localparam int FRAME_BEATS = frame_beats(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int BEAT_W      = ($clog2(FRAME_BEATS + 1) > 18) ? $clog2(FRAME_BEATS + 1) : 18;
    localparam int LEN_W       = 9;
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING) + 1;

    rd_state_t         state;
    logic              latest_buf;
    logic              new_avail;
    logic [BEAT_W-1:0] beat_idx;
    logic [BEAT_W-1:0] beats_left;
    logic [BEAT_W-1:0] next_beat_idx;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  issue_len;
    logic [ADDR_W-1:0] issue_addr;
    logic              has_credit;
    logic              handshake;
    logic [CNT_W-1:0]  outstanding;

    assign beats_left    = BEAT_W'(FRAME_BEATS) - beat_idx;
    assign issue_len     = (beats_left < BEAT_W'(BURST_BEATS)) ? LEN_W'(beats_left)
                                                               : LEN_W'(BURST_BEATS);
    assign issue_addr    = FB_BASE + (rd_buf_idx ? FB_STRIDE : '0)
                         + ADDR_W'(beat_idx) * ADDR_W'(BYTES_PER_BEAT);
    assign next_beat_idx = beat_idx + BEAT_W'(cur_len);
    assign handshake     = (state == REQ) && dma.req_ready;

    display_read_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .LEN_W           (LEN_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .add_en      (handshake),
        .add_len     (cur_len),
        .beat_rx     (dma.beat_rx),
        .chk_len     (issue_len),
        .has_credit  (has_credit),
        .outstanding (outstanding)
    );

    // Frame sequencing, burst generation, miss detection and writer tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            latest_buf     <= 1'b0;
            new_avail      <= 1'b0;
            beat_idx       <= '0;
            cur_len        <= '0;
            dma.req_valid  <= 1'b0;
            dma.req_addr   <= '0;
            dma.req_len    <= '0;
            rd_buf_idx     <= 1'b0;
            rd_busy        <= 1'b0;
            frame_miss     <= 1'b0;
            frame_miss_cnt <= '0;
            frames_read    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (vs_fall) begin
                        // Without a fresh buffer the previous one is shown again.
                        if (new_avail) begin
                            rd_buf_idx <= latest_buf;
                        end
                        new_avail <= 1'b0;
                        beat_idx  <= '0;
                        rd_busy   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (has_credit) begin
                        dma.req_valid <= 1'b1;
                        dma.req_addr  <= issue_addr;
                        dma.req_len   <= 8'(issue_len - LEN_W'(1));
                        cur_len       <= issue_len;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (dma.req_ready) begin
                        dma.req_valid <= 1'b0;
                        beat_idx      <= next_beat_idx;
                        state         <= (next_beat_idx == BEAT_W'(FRAME_BEATS)) ? DRAIN : ISSUE;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        rd_busy     <= 1'b0;
                        frames_read <= frames_read + 16'd1;
                        state       <= enable ? WAIT_VS : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (vs_fall && ((state == ISSUE) || (state == REQ) || (state == DRAIN))) begin
                frame_miss <= 1'b1;
                if (frame_miss_cnt != 16'hFFFF) begin
                    frame_miss_cnt <= frame_miss_cnt + 16'd1;
                end
            end

            // Placed last so a write completing on the frame-start cycle stays pending.
            if (wr_frame_done) begin
                latest_buf <= wr_buf_idx;
                new_avail  <= 1'b1;
            end
        end
    end

endmodule
